// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and queued
// MDU results; the pipeline always wins, and starvation of the queue raises stall_o.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_regwrite,
    input  logic [ADDR_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       mdu_valid,
    input  logic [ADDR_W-1:0]          mdu_rd,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic          stall_reg, stall_next;

    logic pipe_w;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign pipe_w = wb_regwrite & (wb_rd != '0);
    assign full   = (count_reg == CW'(DEPTH));
    assign empty  = (count_reg == '0);

    // Readiness depends only on the stored count, so a same-cycle pop never frees a slot.
    assign mdu_ready = ~rst & ~full;
    assign push      = mdu_valid & mdu_ready & (mdu_rd != '0);
    assign pop       = ~rst & ~pipe_w & ~empty;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (pipe_w) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_data;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = rd_mem[rd_ptr_reg];
                rf_wdata = data_mem[rd_ptr_reg];
            end
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Counts cycles the queue is held off by the pipeline; saturates so stall_o holds.
    always_comb begin
        starve_next = starve_reg;
        if (pop || empty) begin
            starve_next = '0;
        end else if (pipe_w && (starve_reg != SW'(STARVE_LIMIT))) begin
            starve_next = starve_reg + SW'(1);
        end
        stall_next = (starve_next == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
        end
    end

    // Storage needs no reset: entries are only read while the count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= mdu_rd;
            data_mem[wr_ptr_reg] <= mdu_data;
        end
    end

    assign stall_o    = stall_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: directed cases with fixed expectations plus
// randomized traffic compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_regwrite;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_o;
    logic [1:0]        fifo_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   m_starve;
    bit   m_stall;

    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ready;
    logic [1:0]        exp_count;
    logic              exp_stall;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_o(stall_o), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_stall  = 0;
    endtask

    // Apply one clock edge of the reference rules using the inputs held this cycle.
    task automatic model_edge();
        bit   pipe, popped, was_busy, accept;
        ent_t e;
        pipe     = wb_regwrite && (wb_rd != 0);
        was_busy = (q.size() != 0);
        popped   = !pipe && was_busy;
        accept   = mdu_valid && (q.size() < DEPTH);
        if (popped) void'(q.pop_front());
        if (accept && mdu_rd != 0) begin
            e.rd = mdu_rd;
            e.data = mdu_data;
            q.push_back(e);
        end
        if (popped || !was_busy) m_starve = 0;
        else if (pipe && m_starve < LIMIT) m_starve++;
        if (m_starve == LIMIT) m_stall = 1;
        if (popped || q.size() == 0) m_stall = 0;
    endtask

    task automatic model_comb();
        bit pipe;
        pipe      = wb_regwrite && (wb_rd != 0);
        exp_ready = (q.size() < DEPTH);
        exp_count = 2'(q.size());
        exp_stall = m_stall;
        exp_we    = 0;
        exp_addr  = '0;
        exp_data  = '0;
        if (pipe) begin
            exp_we = 1; exp_addr = wb_rd; exp_data = wb_data;
        end else if (q.size() != 0) begin
            exp_we = 1; exp_addr = q[0].rd; exp_data = q[0].data;
        end
    endtask

    // Advance one cycle, present new inputs after the falling edge, settle.
    task automatic step(input bit wr, input logic [ADDR_W-1:0] wrd, input logic [DATA_W-1:0] wdat,
                        input bit mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdat,
                        input bit obey);
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        wb_regwrite = wr & !(obey & stall_o);
        wb_rd       = wrd;
        wb_data     = wdat;
        mdu_valid   = mv;
        mdu_rd      = mrd;
        mdu_data    = mdat;
        #1;
        model_comb();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        model_reset();
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", rf_we); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", mdu_ready); end
        total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_o); end
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b want=1", mdu_ready); end
    endtask

    task automatic test_single();
        step(0, 0, 0, 1, 5, 32'h11, 0);
        total++; if (mdu_ready !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL single_accept ready=%0b we=%0b want ready=1 we=0", mdu_ready, rf_we); end
        idle();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11 || fifo_count !== 2'd1) begin
            bad++; $display("FAIL single_write we=%0b addr=%0d data=%h cnt=%0d want 1/5/11/1",
                            rf_we, rf_waddr, rf_wdata, fifo_count); end
        idle();
        total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL single_drained we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 5; i++) begin
            step(1, 3, 32'hAA, i < 2, (i == 0) ? 5'd7 : 5'd8, (i == 0) ? 32'h1 : 32'h2, 0);
            total++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAA || stall_o !== 1'b0 ||
                fifo_count !== 2'((i < 2) ? i : 2) || mdu_ready !== (i < 2)) begin
                bad++;
                $display("FAIL starve_cyc%0d we=%0b addr=%0d data=%h stall=%0b cnt=%0d rdy=%0b want 1/3/aa/0/%0d/%0b",
                         i, rf_we, rf_waddr, rf_wdata, stall_o, fifo_count, mdu_ready, (i < 2) ? i : 2, i < 2);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        total++; if (stall_o !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1) begin
            bad++; $display("FAIL starve_drain7 stall=%0b we=%0b addr=%0d data=%h want 1/1/7/1",
                            stall_o, rf_we, rf_waddr, rf_wdata); end
        idle();
        total++; if (stall_o !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h2) begin
            bad++; $display("FAIL starve_drain8 stall=%0b we=%0b addr=%0d data=%h want 0/1/8/2",
                            stall_o, rf_we, rf_waddr, rf_wdata); end
        idle();
        total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL starve_empty we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
    endtask

    task automatic test_full_pop();
        step(1, 3, 32'hAA, 1, 9, 32'h90, 0);
        step(1, 3, 32'hAA, 1, 10, 32'hA0, 0);
        step(0, 0, 0, 1, 11, 32'hB0, 0);
        total++; if (mdu_ready !== 1'b0 || fifo_count !== 2'd2 || rf_waddr !== 5'd9 || rf_wdata !== 32'h90) begin
            bad++; $display("FAIL full_pop rdy=%0b cnt=%0d addr=%0d data=%h want 0/2/9/90",
                            mdu_ready, fifo_count, rf_waddr, rf_wdata); end
        step(1, 3, 32'hAA, 1, 11, 32'hB0, 0);
        total++; if (mdu_ready !== 1'b1 || fifo_count !== 2'd1) begin
            bad++; $display("FAIL full_retry rdy=%0b cnt=%0d want 1/1", mdu_ready, fifo_count); end
        idle();
        total++; if (fifo_count !== 2'd2 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA0) begin
            bad++; $display("FAIL full_after cnt=%0d addr=%0d data=%h want 2/10/a0", fifo_count, rf_waddr, rf_wdata); end
        idle();
        total++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'hB0) begin
            bad++; $display("FAIL full_new addr=%0d data=%h want 11/b0", rf_waddr, rf_wdata); end
        idle();
    endtask

    task automatic test_zero_rd();
        step(1, 0, 32'h55, 1, 0, 32'hFF, 0);
        total++; if (mdu_ready !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL zero_rd rdy=%0b we=%0b want 1/0", mdu_ready, rf_we); end
        idle();
        total++; if (fifo_count !== 2'd0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            bad++; $display("FAIL zero_rd_after cnt=%0d we=%0b addr=%0d data=%h want 0/0/0/0",
                            fifo_count, rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++)
            step(1, 3, 32'hAA, i < 2, (i == 0) ? 5'd7 : 5'd8, 32'h5, 0);
        total++; if (stall_o !== 1'b1 || fifo_count !== 2'd2) begin
            bad++; $display("FAIL midrst_setup stall=%0b cnt=%0d want 1/2", stall_o, fifo_count); end
        #2 rst = 1;
        #1;
        total++; if (fifo_count !== 2'd0 || stall_o !== 1'b0 || rf_we !== 1'b0 || mdu_ready !== 1'b0 ||
                     rf_waddr !== 5'd0) begin
            bad++; $display("FAIL midrst cnt=%0d stall=%0b we=%0b rdy=%0b addr=%0d want 0/0/0/0/0",
                            fifo_count, stall_o, rf_we, mdu_ready, rf_waddr); end
        model_reset();
        @(negedge clk);
        wb_regwrite = 0; wb_rd = 0; mdu_valid = 0; mdu_rd = 0;
        rst = 0;
        #1;
        total++; if (mdu_ready !== 1'b1 || fifo_count !== 2'd0) begin
            bad++; $display("FAIL midrst_release rdy=%0b cnt=%0d want 1/0", mdu_ready, fifo_count); end
    endtask

    task automatic test_wrap_order();
        int pushed = 0;
        int seen   = 0;
        for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
            step(cyc % 2 == 0, 20, 32'h2020, pushed < 6, 5'(pushed + 1), 32'(pushed + 1), 0);
            if (mdu_valid && mdu_ready) pushed++;
            if (rf_we && !wb_regwrite) begin
                total++;
                if (rf_waddr !== 5'(seen + 1) || rf_wdata !== 32'(seen + 1)) begin
                    bad++; $display("FAIL wrap_order idx=%0d addr=%0d data=%h want %0d", seen, rf_waddr, rf_wdata, seen + 1);
                end
                seen++;
            end
        end
        total++; if (seen != 6) begin bad++; $display("FAIL wrap_timeout seen=%0d want 6", seen); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom, 1);
            total++; if (rf_we !== exp_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%0b want=%0b", n, rf_we, exp_we); end
            total++; if (rf_waddr !== exp_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%0d want=%0d", n, rf_waddr, exp_addr); end
            total++; if (rf_wdata !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", n, rf_wdata, exp_data); end
            total++; if (mdu_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", n, mdu_ready, exp_ready); end
            total++; if (fifo_count !== exp_count) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", n, fifo_count, exp_count); end
            total++; if (stall_o !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b want=%0b", n, stall_o, exp_stall); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_starvation();
        test_full_pop();
        test_zero_rd();
        test_reset_mid();
        test_wrap_order();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two sources.
- Source 1 is the pipeline WB stage: W_data_WB plus its destination register and RegWrite.
- Source 2 is the multi-cycle multiply/divide unit (MDU), which completes out of band.
- The pipeline always has priority. MDU results are queued in a small FIFO and drained in free WB slots. A starvation counter forces a pipeline bubble when the queue is not draining.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles with a non-empty FIFO before stall_o is raised (≥1)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- wb_regwrite  in  1  pipeline WB write request
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline write data (W_data_WB)
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept; transfer occurs when mdu_valid & mdu_ready at a clk edge
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- stall_o  out  1  registered; requests a WB bubble next cycle
- fifo_count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - FIFO emptied; read and write pointers = 0; fifo_count = 0.
  - Starvation counter = 0; stall_o = 0.
  - mdu_ready = 0 while rst is high, then !full.
  - rf_we = 0 while rst is high.
  - rf_waddr / rf_wdata = 0 when rf_we = 0.
- Pipeline write valid: pipe_w = wb_regwrite & (wb_rd != 0).
- Port selection (combinational, same cycle):
  - If pipe_w: rf_we = 1, rf_waddr = wb_rd, rf_wdata = wb_data. The FIFO is not popped.
  - Else if FIFO non-empty: rf_we = 1 with the head entry; head popped at the clk edge.
  - Else: rf_we = 0.
- Enqueue:
  - On mdu_valid & mdu_ready with mdu_rd != 0, push {mdu_rd, mdu_data}.
  - With mdu_rd == 0 the handshake completes but nothing is pushed.
  - No bypass: an MDU result reaches rf_we at the earliest one cycle after acceptance.
- mdu_ready = !full, computed from the current count only. A pop in the same cycle does not enable a push when full.
- Simultaneous push and pop (not full): count unchanged; both pointers advance and wrap modulo DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and pipe_w = 1, saturating at STARVE_LIMIT.
  - Clears on any pop and whenever the FIFO is empty.
- stall_o:
  - Set at the clk edge where the counter's next value equals STARVE_LIMIT.
  - Cleared at the edge of the next pop or when the FIFO becomes empty.
  - While stall_o = 1 the upstream hazard unit presents wb_regwrite = 0.
  - If pipe_w is still asserted during stall_o, the pipeline still wins, the counter stays saturated, and stall_o stays high.
- Ordering between a queued MDU write and a later pipeline write to the same register is the hazard unit's responsibility. This block preserves FIFO order among MDU results only.
- The FIFO never overflows (push is gated by mdu_ready) and never underflows (pop is gated by non-empty).

Test Plan:
- Reset, then mdu_valid=1, mdu_rd=5, mdu_data=0x11, pipeline idle:
  - Accepted at edge 1 (count 1).
  - Next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11.
  - Count back to 0 after that edge.
- Pipeline writes r3=0xAA every cycle while the MDU pushes r7=0x1 then r8=0x2:
  - Both queued; mdu_ready=0 at count 2.
  - rf port shows only r3 writes.
  - stall_o rises after 4 blocked cycles.
  - Upstream drops wb_regwrite: r7 is drained, then r8 on the following bubble.
- FIFO full, MDU pops head and offers a new result in the same cycle:
  - The new result is not accepted that cycle.
  - It is accepted on the next cycle (count 1→2).
- mdu_rd=0 with mdu_data=0xFF, and wb_rd=0 with wb_regwrite=1:
  - Handshake completes; count stays 0; rf_we=0.
- Assert rst while count=2 and stall_o=1:
  - count=0, stall_o=0, rf_we=0, mdu_ready=0 immediately, without waiting for a clock edge.
  - After release, mdu_ready=1.
- Push 6 results r1..r6 (data=rd) across pointer wrap with alternating pipeline idle cycles:
  - rf writes occur in order r1..r6 with the matching data.
